// File: rtl/cplx_gate_bist.sv
// rtl/cplx_gate_bist.sv - exhaustive OAI22/AOI22 cell self-test engine with error count and first-fail capture
// Optional MISR signature on the sampled Y stream is built when CPLX_BIST_MISR_EN is defined.
module cplx_gate_bist #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        mode,
  input  logic        y,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  errcnt,
  output logic [3:0]  fail_vec,
  output logic [15:0] sig
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  logic [1:0] state;
  logic [3:0] vec;
  logic [3:0] cnt;
  logic [3:0] stim;
  logic       mode_q;
  logic       gold;
  logic       mismatch;
  logic       last_window;

  assign {a, b, c, d} = stim;
  assign busy = (state == ST_RUN);
  assign done = (state == ST_FINISH);

  // Golden cell response for the vector currently driven; A is vec[3].
  always_comb begin
    gold = 1'b0;
    if (mode_q)
      gold = ~((vec[3] & vec[2]) | (vec[1] & vec[0]));
    else
      gold = ~((vec[3] | vec[2]) & (vec[1] | vec[0]));
  end

  assign mismatch    = (y != gold);
  assign last_window = (cnt == SETTLE_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      vec      <= 4'd0;
      cnt      <= 4'd0;
      stim     <= 4'd0;
      mode_q   <= 1'b0;
      pass     <= 1'b0;
      errcnt   <= 5'd0;
      fail_vec <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            vec      <= 4'd0;
            cnt      <= 4'd0;
            stim     <= 4'd0;
            mode_q   <= mode;
            pass     <= 1'b0;
            errcnt   <= 5'd0;
            fail_vec <= 4'd0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
            stim  <= 4'd0;
            pass  <= 1'b0;
          end else if (last_window) begin
            if (mismatch) begin
              errcnt <= errcnt + 5'd1;
              if (errcnt == 5'd0)
                fail_vec <= vec;
            end
            cnt <= 4'd0;
            if (vec == 4'hF) begin
              state <= ST_FINISH;
              stim  <= 4'd0;
              // Include the final sample, which has not reached errcnt yet.
              pass  <= (errcnt == 5'd0) && !mismatch;
            end else begin
              vec  <= vec + 4'd1;
              stim <= vec + 4'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CPLX_BIST_MISR_EN
  logic        sample;
  logic [15:0] sig_q;

  assign sample = (state == ST_RUN) && !abort && last_window;

  // CCITT MISR seeded with all ones at run start; one shift per sampled Y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sig_q <= 16'h0000;
    else if ((state == ST_IDLE) && start)
      sig_q <= 16'hFFFF;
    else if (sample)
      sig_q <= {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ y) ? 16'h1021 : 16'h0000);
  end

  assign sig = sig_q;
`else
  assign sig = 16'h0000;
`endif

endmodule

// File: tb/tb_cplx_gate_bist.sv
// tb/tb_cplx_gate_bist.sv - randomized bench for cplx_gate_bist against a truth-table reference model
// Two instances: SETTLE=2 for the main runs, SETTLE=0 for the reset/held-START run.
module tb_cplx_gate_bist;

  localparam int W2 = 3;
  localparam int W0 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start2, abort2, mode2, y2;
  logic        a2, b2, c2, d2, busy2, done2, pass2;
  logic [4:0]  errcnt2;
  logic [3:0]  fail_vec2;
  logic [15:0] sig2;
  logic        start0, abort0, mode0, y0;
  logic        a0, b0, c0, d0, busy0, done0, pass0;
  logic [4:0]  errcnt0;
  logic [3:0]  fail_vec0;
  logic [15:0] sig0;

  // Cell under test modelled as a truth table indexed by {A,B,C,D}.
  logic [15:0] tt2, tt0;
  assign y2 = tt2[{a2, b2, c2, d2}];
  assign y0 = tt0[{a0, b0, c0, d0}];

  int n_checks = 0;
  int n_pass   = 0;

  cplx_gate_bist #(.SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .mode(mode2), .y(y2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2), .pass(pass2),
    .errcnt(errcnt2), .fail_vec(fail_vec2), .sig(sig2)
  );

  cplx_gate_bist #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .mode(mode0), .y(y0),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .pass(pass0),
    .errcnt(errcnt0), .fail_vec(fail_vec0), .sig(sig0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic golden(input logic m, input logic [3:0] v);
    logic ia, ib, ic, id;
    {ia, ib, ic, id} = v;
    return m ? ~((ia & ib) | (ic & id)) : ~((ia | ib) & (ic | id));
  endfunction

  function automatic logic [15:0] golden_tt(input logic m);
    logic [15:0] t;
    for (int v = 0; v < 16; v++) t[v] = golden(m, 4'(v));
    return t;
  endfunction

  // Expected results after the first n vectors have been sampled.
  task automatic ref_model(input logic [15:0] tt, input logic m, input int n,
                           output logic [4:0] e, output logic [3:0] fv, output logic [15:0] s);
    logic yv;
    e = 0; fv = 0; s = 16'hFFFF;
    for (int v = 0; v < n; v++) begin
      yv = tt[v];
      if (yv != golden(m, 4'(v))) begin
        if (e == 0) fv = 4'(v);
        e = e + 5'd1;
      end
      s = {s[14:0], 1'b0} ^ ((s[15] ^ yv) ? 16'h1021 : 16'h0000);
    end
`ifndef CPLX_BIST_MISR_EN
    s = 16'h0000;
`endif
  endtask

  task automatic run2(input string tag, input logic [15:0] tt_in, input logic m,
                      input int abort_at, input int extra_start, input bit abort_w);
    int k, nb, limit;
    bit saw_done;
    logic [4:0] e;
    logic [3:0] fv;
    logic [15:0] s;
    tt2 = tt_in;
    @(negedge clk);
    mode2 = m; start2 = 1'b1; abort2 = abort_w;
    @(negedge clk);
    start2 = 1'b0; abort2 = 1'b0;
    limit = (abort_at >= 0) ? abort_at + 4 : 300;
    k = 0; nb = 0; saw_done = 0;
    while (k < limit) begin
      if (done2) begin saw_done = 1; break; end
      if (busy2) nb++;
      if (abort_at >= 0 && k == abort_at) begin
        check({tag, "_abort_busy"}, busy2, 0);
        check({tag, "_abort_stim"}, {a2, b2, c2, d2}, 0);
        check({tag, "_abort_pass"}, pass2, 0);
      end
      mode2  = 1'($urandom);
      start2 = (k == extra_start);
      abort2 = (abort_at >= 0 && k == abort_at - 1);
      @(negedge clk);
      k++;
    end
    start2 = 1'b0; abort2 = 1'b0;
    if (abort_at >= 0) begin
      ref_model(tt_in, m, (abort_at - 1) / W2, e, fv, s);
      check({tag, "_no_done"}, saw_done, 0);
      check({tag, "_busy_cycles"}, nb, abort_at);
    end else begin
      ref_model(tt_in, m, 16, e, fv, s);
      check({tag, "_done_seen"}, saw_done, 1);
      check({tag, "_done_cycle"}, k, 16 * W2);
      check({tag, "_busy_cycles"}, nb, 16 * W2);
      check({tag, "_pass"}, pass2, (e == 0));
      check({tag, "_stim_idle"}, {a2, b2, c2, d2}, 0);
    end
    check({tag, "_errcnt"}, errcnt2, e);
    check({tag, "_fail_vec"}, fail_vec2, fv);
    check({tag, "_sig"}, sig2, s);
    if (abort_at < 0) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, {busy2, done2}, 0);
      check({tag, "_pass_held"}, pass2, (e == 0));
    end
  endtask

  task automatic reset_test();
    int k, nb;
    bit saw_done;
    tt0 = golden_tt(1'b0); mode0 = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    for (k = 0; k < 9; k++) @(negedge clk);
    check("rst_midrun_busy_before", busy0, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {a0, b0, c0, d0, busy0, done0, pass0, errcnt0, fail_vec0, sig0}, 0);
    @(negedge clk);
    check("rst_held_outputs", {a0, b0, c0, d0, busy0, done0, pass0, errcnt0, fail_vec0, sig0}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    k = 0; nb = 0; saw_done = 0;
    while (k < 100) begin
      if (done0) begin saw_done = 1; break; end
      if (busy0) nb++;
      @(negedge clk);
      k++;
    end
    start0 = 1'b0;
    check("rst_rerun_done_seen", saw_done, 1);
    check("rst_rerun_done_cycle", k, 16 * W0);
    check("rst_rerun_busy_cycles", nb, 16 * W0);
    check("rst_rerun_result", {pass0, errcnt0}, {1'b1, 5'd0});
    @(negedge clk);
    check("rst_rerun_idle", {busy0, done0}, 0);
  endtask

  initial begin
    logic m;
    logic [15:0] mask;
    rst_n = 1'b0;
    start2 = 0; abort2 = 0; mode2 = 0;
    start0 = 0; abort0 = 0; mode0 = 0;
    tt2 = golden_tt(1'b0); tt0 = golden_tt(1'b0);
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {a2, b2, c2, d2, busy2, done2, pass2, errcnt2, fail_vec2, sig2}, 0);
    check("reset_outputs0", {a0, b0, c0, d0, busy0, done0, pass0, errcnt0, fail_vec0, sig0}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run2("oai_ideal", golden_tt(1'b0), 1'b0, -1, 10, 1'b0);
    run2("stuck0", 16'h0000, 1'b0, -1, -1, 1'b0);
    check("stuck0_spec", {errcnt2, fail_vec2}, {5'd7, 4'b0000});
    run2("stuck1", 16'hFFFF, 1'b0, -1, -1, 1'b0);
    check("stuck1_spec", {errcnt2, fail_vec2}, {5'd9, 4'b0101});
    run2("aoi_as_oai", golden_tt(1'b1), 1'b0, -1, -1, 1'b0);
    check("aoi_as_oai_spec", {errcnt2, fail_vec2}, {5'd6, 4'b0011});
    run2("aoi_start_wins", golden_tt(1'b1), 1'b1, -1, -1, 1'b1);
    run2("abort", 16'h0000, 1'b0, 20, -1, 1'b0);
    run2("after_abort", golden_tt(1'b0), 1'b0, -1, -1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      m = 1'($urandom);
      mask = 16'($urandom & $urandom & $urandom);
      run2($sformatf("rand%0d", i), golden_tt(m) ^ mask, m, -1, $urandom_range(0, 40), 1'b0);
    end
    reset_test();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
